// File: rtl/add32_seq.sv
// Sequential 32-bit adder: one 8-bit ripple-carry adder reused LSB-first over four cycles.
// Define ADD32_SEQ_SUB_EN to add the sub input (a + ~b + 1).
module add32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
`ifdef ADD32_SEQ_SUB_EN
    input  logic        sub,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        cout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
`ifdef ADD32_SEQ_SUB_EN
    logic        sub_q, sub_d;
`endif

    logic [7:0]  byte_a, byte_b, byte_s;
    logic        byte_co;
    logic        rc;

    always_comb begin
        byte_a = 8'h00;
        byte_b = 8'h00;
        case (idx_q)
            2'd0:    begin byte_a = a_q[7:0];   byte_b = b_q[7:0];   end
            2'd1:    begin byte_a = a_q[15:8];  byte_b = b_q[15:8];  end
            2'd2:    begin byte_a = a_q[23:16]; byte_b = b_q[23:16]; end
            default: begin byte_a = a_q[31:24]; byte_b = b_q[31:24]; end
        endcase
`ifdef ADD32_SEQ_SUB_EN
        if (sub_q) byte_b = ~byte_b;
`endif
    end

    // The single shared 8-bit ripple-carry adder.
    always_comb begin
        byte_s = 8'h00;
        rc     = carry_q;
        for (int i = 0; i < 8; i++) begin
            byte_s[i] = byte_a[i] ^ byte_b[i] ^ rc;
            rc        = (byte_a[i] & byte_b[i]) | (rc & (byte_a[i] ^ byte_b[i]));
        end
        byte_co = rc;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADD32_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            StRun: begin
                carry_d = byte_co;
                case (idx_q)
                    2'd0: acc_d[7:0]   = byte_s;
                    2'd1: acc_d[15:8]  = byte_s;
                    2'd2: acc_d[23:16] = byte_s;
                    default: ;
                endcase
                if (idx_q == 2'd3) begin
                    sum_d   = {byte_s, acc_q};
                    cout_d  = byte_co;
                    idx_d   = 2'd0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Accept overrides the DONE->IDLE default; never taken while running.
        if (start && state_q != StRun) begin
            state_d = StRun;
            idx_d   = 2'd0;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
`ifdef ADD32_SEQ_SUB_EN
            sub_d   = sub;
            if (sub) carry_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            acc_q   <= 24'h0;
            sum_q   <= 32'h0;
            cout_q  <= 1'b0;
`ifdef ADD32_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADD32_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_add32_seq.sv
// Directed self-checking bench for add32_seq; define ADD32_SEQ_SUB_EN to also cover subtract.
module tb_add32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        cin;
`ifdef ADD32_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy, done, cout;
    logic [31:0] sum;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_sum;

    always #5 clk = ~clk;

    add32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef ADD32_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation observed over a 10-cycle window after the accept edge.
    // poke: at cycle 1 pulse start with a different a and scramble the operand inputs.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic [31:0] es, input logic ec, input bit poke);
        int first_done, done_cnt, busy_cnt;
        bit early;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        first_done = -1; done_cnt = 0; busy_cnt = 0; early = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
            end
            if (busy) busy_cnt++;
            if (first_done < 0 && sum !== last_sum) early = 1'b1;
            if (poke && c == 1) begin
                a = ~ta; b = ~tb_v; cin = ~tc; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check_eq({tag, "_latency"}, first_done, 4);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 4);
        check_eq({tag, "_sum_held"}, {31'd0, early}, 32'd0);
        check_eq({tag, "_sum"}, sum, es);
        check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        last_sum = es;
    endtask

    initial begin
        int n_done;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADD32_SEQ_SUB_EN
        sub = 1'b0;
`endif
        tick(); tick();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum", sum, 32'h0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        last_sum = 32'h0;
        tick();

        do_op("carry_chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        do_op("plain_add", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        do_op("ignored_start", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
        do_op("byte_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

        // Reset two cycles into a run; start asserted during reset must be ignored.
        a = 32'd3; b = 32'd4; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_sum", sum, 32'h0);
        check_eq("abort_cout", {31'd0, cout}, 32'd0);
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) n_done++;
            tick();
        end
        check_eq("abort_no_done", n_done, 0);
        last_sum = 32'h0;
        do_op("after_abort", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0);

        // Back-to-back: start held high.
        a = 32'd5; b = 32'd7; cin = 1'b0; start = 1'b1;
        tick();
        n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done) begin
                n_done++;
                check_eq("b2b_phase", c % 5, 4);
                check_eq("b2b_sum", sum, 32'h0000_000C);
            end
        end
        check_eq("b2b_done_cnt", n_done, 4);
        start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check_eq("b2b_idle", {31'd0, busy}, 32'd0);
        last_sum = 32'h0000_000C;

`ifdef ADD32_SEQ_SUB_EN
        sub = 1'b1;
        do_op("sub_neg", 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_pos", 32'd7, 32'd5, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
